// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Tag/data widths, null encodings and the ROB entry record shared
//               by the ROB, the map table and the reservation stations.
// Revision    : 1.0
// ============================================================================
package reorder_buffer_pkg;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    localparam logic [TAG_W-1:0] RSTAG_NULL = 8'hFF;
    localparam logic [REG_W-1:0] ZERO_REG   = 5'h1f;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    // Tags carry the entry index in the low six bits; bit 6 belongs to the map table.
    function automatic logic [TAG_W-1:0] make_tag(input logic [5:0] idx);
        return {2'b00, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_entry_slot.sv
`default_nettype none
// ============================================================================
// Module      : rob_entry_slot
// Description : One reorder-buffer entry: allocation, CDB capture and clear.
// Revision    : 1.0
// ============================================================================
module rob_entry_slot
    import reorder_buffer_pkg::*;
#(
    parameter int INDEX = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic              clear,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_value,
    input  logic [TAG_W-1:0]  cdb2_tag,
    input  logic [DATA_W-1:0] cdb2_value,
    output rob_entry_t        entry
);

    localparam logic [5:0] c_index = 6'(INDEX);

    rob_entry_t r_entry;
    logic       w_hit1;
    logic       w_hit2;

    assign w_hit1 = (cdb1_tag != RSTAG_NULL) && (cdb1_tag[5:0] == c_index);
    assign w_hit2 = (cdb2_tag != RSTAG_NULL) && (cdb2_tag[5:0] == c_index);
    assign entry  = r_entry;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_entry.valid    <= 1'b0;
            r_entry.complete <= 1'b0;
            r_entry.dest     <= ZERO_REG;
            r_entry.value    <= '0;
        end else if (clear) begin
            r_entry.valid    <= 1'b0;
            r_entry.complete <= 1'b0;
        end else if (alloc) begin
            r_entry.valid    <= 1'b1;
            r_entry.complete <= 1'b0;
            r_entry.dest     <= alloc_dest;
            r_entry.value    <= '0;
        end else if (r_entry.valid) begin
            // CDB1 takes precedence when both ports name this entry.
            if (w_hit1) begin
                r_entry.complete <= 1'b1;
                r_entry.value    <= cdb1_value;
            end else if (w_hit2) begin
                r_entry.complete <= 1'b1;
                r_entry.value    <= cdb2_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Two-wide in-order reorder buffer: dispatch tag allocation,
//               CDB completion capture and in-order dual retire.
// Revision    : 1.0
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ENTRIES = 32,
    parameter int IDX_BITS    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_in,
    input  logic              inst1_valid_in,
    input  logic [REG_W-1:0]  inst1_dest_in,
    input  logic              inst2_valid_in,
    input  logic [REG_W-1:0]  inst2_dest_in,
    input  logic [TAG_W-1:0]  cdb1_tag_in,
    input  logic [DATA_W-1:0] cdb1_value_in,
    input  logic [TAG_W-1:0]  cdb2_tag_in,
    input  logic [DATA_W-1:0] cdb2_value_in,
    output logic [TAG_W-1:0]  inst1_tag_out,
    output logic [TAG_W-1:0]  inst2_tag_out,
    output logic              full_out,
    output logic              empty_out,
    output logic [TAG_W-1:0]  inst1_retire_tag_out,
    output logic [REG_W-1:0]  inst1_retire_dest_out,
    output logic [DATA_W-1:0] inst1_retire_value_out,
    output logic [TAG_W-1:0]  inst2_retire_tag_out,
    output logic [REG_W-1:0]  inst2_retire_dest_out,
    output logic [DATA_W-1:0] inst2_retire_value_out
);

    localparam logic [IDX_BITS-1:0] c_idx_one  = IDX_BITS'(1);
    localparam logic [IDX_BITS:0]   c_full_lim = (IDX_BITS+1)'(ROB_ENTRIES - 2);

    logic [IDX_BITS-1:0] r_head;
    logic [IDX_BITS-1:0] r_tail;
    logic [IDX_BITS:0]   r_count;

    rob_entry_t          w_entry [ROB_ENTRIES];
    logic                w_block;
    logic                w_full;
    logic                w_alloc1;
    logic                w_alloc2;
    logic [IDX_BITS-1:0] w_idx2;
    logic [IDX_BITS-1:0] w_head_p1;
    logic                w_ret1;
    logic                w_ret2;
    logic [1:0]          w_n_alloc;
    logic [1:0]          w_n_ret;

    assign w_block   = reset || flush_in;
    assign w_full    = r_count > c_full_lim;
    assign w_alloc1  = !w_full && !w_block && inst1_valid_in;
    assign w_alloc2  = !w_full && !w_block && inst2_valid_in;
    assign w_idx2    = inst1_valid_in ? r_tail + c_idx_one : r_tail;
    assign w_head_p1 = r_head + c_idx_one;
    assign w_ret1    = !w_block && w_entry[r_head].valid && w_entry[r_head].complete;
    assign w_ret2    = w_ret1 && w_entry[w_head_p1].valid && w_entry[w_head_p1].complete;
    assign w_n_alloc = {1'b0, w_alloc1} + {1'b0, w_alloc2};
    assign w_n_ret   = {1'b0, w_ret1} + {1'b0, w_ret2};

    assign full_out  = w_full;
    assign empty_out = (r_count == '0);

    always_comb begin
        inst1_tag_out          = RSTAG_NULL;
        inst2_tag_out          = RSTAG_NULL;
        inst1_retire_tag_out   = RSTAG_NULL;
        inst1_retire_dest_out  = ZERO_REG;
        inst1_retire_value_out = '0;
        inst2_retire_tag_out   = RSTAG_NULL;
        inst2_retire_dest_out  = ZERO_REG;
        inst2_retire_value_out = '0;
        if (w_alloc1) begin
            inst1_tag_out = make_tag(6'(r_tail));
        end
        if (w_alloc2) begin
            inst2_tag_out = make_tag(6'(w_idx2));
        end
        if (w_ret1) begin
            inst1_retire_tag_out   = make_tag(6'(r_head));
            inst1_retire_dest_out  = w_entry[r_head].dest;
            inst1_retire_value_out = w_entry[r_head].value;
        end
        if (w_ret2) begin
            inst2_retire_tag_out   = make_tag(6'(w_head_p1));
            inst2_retire_dest_out  = w_entry[w_head_p1].dest;
            inst2_retire_value_out = w_entry[w_head_p1].value;
        end
    end

    generate
        for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_slot
            logic w_sel1;
            logic w_sel2;
            logic w_clear;

            assign w_sel1  = w_alloc1 && (r_tail == IDX_BITS'(gi));
            assign w_sel2  = w_alloc2 && (w_idx2 == IDX_BITS'(gi));
            assign w_clear = (w_ret1 && (r_head == IDX_BITS'(gi))) ||
                             (w_ret2 && (w_head_p1 == IDX_BITS'(gi)));

            rob_entry_slot #(
                .INDEX (gi)
            ) u_slot (
                .clock      (clock),
                .reset      (reset),
                .flush      (flush_in),
                .alloc      (w_sel1 || w_sel2),
                .alloc_dest (w_sel1 ? inst1_dest_in : inst2_dest_in),
                .clear      (w_clear),
                .cdb1_tag   (cdb1_tag_in),
                .cdb1_value (cdb1_value_in),
                .cdb2_tag   (cdb2_tag_in),
                .cdb2_value (cdb2_value_in),
                .entry      (w_entry[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset || flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + IDX_BITS'(w_n_alloc);
            r_head  <= r_head + IDX_BITS'(w_n_ret);
            r_count <= r_count + (IDX_BITS+1)'(w_n_alloc) - (IDX_BITS+1)'(w_n_ret);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed bench for reorder_buffer with a circular-array model.
// Revision    : 1.0
// ============================================================================
module tb_reorder_buffer;

    localparam int N = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_in;
    logic        inst1_valid_in;
    logic [4:0]  inst1_dest_in;
    logic        inst2_valid_in;
    logic [4:0]  inst2_dest_in;
    logic [7:0]  cdb1_tag_in;
    logic [63:0] cdb1_value_in;
    logic [7:0]  cdb2_tag_in;
    logic [63:0] cdb2_value_in;
    logic [7:0]  inst1_tag_out;
    logic [7:0]  inst2_tag_out;
    logic        full_out;
    logic        empty_out;
    logic [7:0]  inst1_retire_tag_out;
    logic [4:0]  inst1_retire_dest_out;
    logic [63:0] inst1_retire_value_out;
    logic [7:0]  inst2_retire_tag_out;
    logic [4:0]  inst2_retire_dest_out;
    logic [63:0] inst2_retire_value_out;

    reorder_buffer #(
        .ROB_ENTRIES (N),
        .IDX_BITS    (5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .flush_in               (flush_in),
        .inst1_valid_in         (inst1_valid_in),
        .inst1_dest_in          (inst1_dest_in),
        .inst2_valid_in         (inst2_valid_in),
        .inst2_dest_in          (inst2_dest_in),
        .cdb1_tag_in            (cdb1_tag_in),
        .cdb1_value_in          (cdb1_value_in),
        .cdb2_tag_in            (cdb2_tag_in),
        .cdb2_value_in          (cdb2_value_in),
        .inst1_tag_out          (inst1_tag_out),
        .inst2_tag_out          (inst2_tag_out),
        .full_out               (full_out),
        .empty_out              (empty_out),
        .inst1_retire_tag_out   (inst1_retire_tag_out),
        .inst1_retire_dest_out  (inst1_retire_dest_out),
        .inst1_retire_value_out (inst1_retire_value_out),
        .inst2_retire_tag_out   (inst2_retire_tag_out),
        .inst2_retire_dest_out  (inst2_retire_dest_out),
        .inst2_retire_value_out (inst2_retire_value_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: ring of entries with head/tail/count ----------------
    bit          m_valid [N];
    bit          m_comp  [N];
    logic [4:0]  m_dest  [N];
    logic [63:0] m_val   [N];
    int          m_head  = 0;
    int          m_tail  = 0;
    int          m_count = 0;
    bit          started = 0;

    function automatic bit cdb_hits(input logic [7:0] tag, input int idx);
        return (tag != 8'hFF) && (int'(tag[5:0]) == idx);
    endfunction

    always @(posedge clock) begin
        int  nr;
        int  na;
        bit  r1;
        bit  r2;
        bit  acc;
        started = 1;
        if (reset || flush_in) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_comp[i]  = 0;
            end
            m_head  = 0;
            m_tail  = 0;
            m_count = 0;
        end else begin
            r1  = m_valid[m_head] && m_comp[m_head];
            r2  = r1 && m_valid[(m_head + 1) % N] && m_comp[(m_head + 1) % N];
            nr  = int'(r1) + int'(r2);
            acc = (m_count <= N - 2);
            for (int i = 0; i < N; i++) begin
                if (m_valid[i]) begin
                    if (cdb_hits(cdb1_tag_in, i)) begin
                        m_comp[i] = 1;
                        m_val[i]  = cdb1_value_in;
                    end else if (cdb_hits(cdb2_tag_in, i)) begin
                        m_comp[i] = 1;
                        m_val[i]  = cdb2_value_in;
                    end
                end
            end
            for (int k = 0; k < nr; k++) begin
                m_valid[(m_head + k) % N] = 0;
                m_comp[(m_head + k) % N]  = 0;
            end
            m_head = (m_head + nr) % N;
            na = 0;
            if (acc && inst1_valid_in) begin
                m_valid[m_tail] = 1;
                m_comp[m_tail]  = 0;
                m_dest[m_tail]  = inst1_dest_in;
                m_tail = (m_tail + 1) % N;
                na++;
            end
            if (acc && inst2_valid_in) begin
                m_valid[m_tail] = 1;
                m_comp[m_tail]  = 0;
                m_dest[m_tail]  = inst2_dest_in;
                m_tail = (m_tail + 1) % N;
                na++;
            end
            m_count = m_count + na - nr;
        end
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge clock) begin
        bit         blk;
        bit         acc;
        bit         r1;
        bit         r2;
        int         h1;
        logic [7:0] e_t1;
        logic [7:0] e_t2;
        if (started) begin
            blk  = reset || flush_in;
            acc  = !blk && (m_count <= N - 2);
            e_t1 = (acc && inst1_valid_in) ? 8'(m_tail) : 8'hFF;
            e_t2 = (acc && inst2_valid_in) ? 8'(inst1_valid_in ? (m_tail + 1) % N : m_tail) : 8'hFF;
            h1   = (m_head + 1) % N;
            r1   = !blk && m_valid[m_head] && m_comp[m_head];
            r2   = r1 && m_valid[h1] && m_comp[h1];
            chk("inst1_tag", 64'(inst1_tag_out), 64'(e_t1));
            chk("inst2_tag", 64'(inst2_tag_out), 64'(e_t2));
            chk("full", 64'(full_out), 64'(m_count > N - 2));
            chk("empty", 64'(empty_out), 64'(m_count == 0));
            chk("ret1_tag", 64'(inst1_retire_tag_out), r1 ? 64'(m_head) : 64'hFF);
            chk("ret1_dest", 64'(inst1_retire_dest_out), r1 ? 64'(m_dest[m_head]) : 64'h1f);
            chk("ret1_value", inst1_retire_value_out, r1 ? m_val[m_head] : 64'h0);
            chk("ret2_tag", 64'(inst2_retire_tag_out), r2 ? 64'(h1) : 64'hFF);
            chk("ret2_dest", 64'(inst2_retire_dest_out), r2 ? 64'(m_dest[h1]) : 64'h1f);
            chk("ret2_value", inst2_retire_value_out, r2 ? m_val[h1] : 64'h0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        flush_in       = 1'b0;
        inst1_valid_in = 1'b0;
        inst1_dest_in  = 5'd0;
        inst2_valid_in = 1'b0;
        inst2_dest_in  = 5'd0;
        cdb1_tag_in    = 8'hFF;
        cdb1_value_in  = 64'd0;
        cdb2_tag_in    = 8'hFF;
        cdb2_value_in  = 64'd0;
    endtask

    task automatic disp(input bit v1, input logic [4:0] d1, input bit v2, input logic [4:0] d2);
        idle();
        inst1_valid_in = v1;
        inst1_dest_in  = d1;
        inst2_valid_in = v2;
        inst2_dest_in  = d2;
    endtask

    task automatic wait_empty();
        int n = 0;
        idle();
        while (m_count != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(m_count), 64'd0);
    endtask

    // Dispatch single instructions, completing each one the following cycle,
    // until tail reaches the target with the buffer empty.
    task automatic churn_to(input int target);
        logic [7:0] prev = 8'hFF;
        logic [7:0] nxt;
        int         n = 0;
        while (!(m_tail == target && m_count == 0) && n < 200) begin
            idle();
            nxt = 8'hFF;
            if (m_tail != target) begin
                inst1_valid_in = 1'b1;
                inst1_dest_in  = 5'(n % 31);
                nxt = 8'(m_tail);
            end
            cdb1_tag_in   = prev;
            cdb1_value_in = 64'(n) + 64'h1000;
            tick();
            prev = nxt;
            n++;
        end
        chk("churn_timeout", 64'(m_tail), 64'(target));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_full", 64'(full_out), 64'd0);
        chk("rst_empty", 64'(empty_out), 64'd1);
        chk("rst_ret1", 64'(inst1_retire_tag_out), 64'hFF);

        // First dual dispatch.
        disp(1, 5'd3, 1, 5'd4);
        #1;
        chk("d_tag1", 64'(inst1_tag_out), 64'h00);
        chk("d_tag2", 64'(inst2_tag_out), 64'h01);
        tick();
        idle();
        #1;
        chk("d_empty", 64'(empty_out), 64'd0);

        // Younger entry completes first; nothing may retire.
        cdb1_tag_in   = 8'h01;
        cdb1_value_in = 64'h22;
        tick();
        idle();
        #1;
        chk("ooo_hold", 64'(inst1_retire_tag_out), 64'hFF);
        cdb2_tag_in   = 8'h40;
        cdb2_value_in = 64'h11;
        tick();
        idle();
        #1;
        chk("r1_tag", 64'(inst1_retire_tag_out), 64'h00);
        chk("r1_dest", 64'(inst1_retire_dest_out), 64'd3);
        chk("r1_val", inst1_retire_value_out, 64'h11);
        chk("r2_tag", 64'(inst2_retire_tag_out), 64'h01);
        chk("r2_dest", 64'(inst2_retire_dest_out), 64'd4);
        chk("r2_val", inst2_retire_value_out, 64'h22);
        tick();

        // Fill to 31 entries.
        for (int i = 0; i < 15; i++) begin
            disp(1, 5'(i), 1, 5'(i + 1));
            tick();
        end
        disp(1, 5'd5, 0, 5'd0);
        tick();
        idle();
        #1;
        chk("full_set", 64'(full_out), 64'd1);
        disp(1, 5'd1, 1, 5'd2);
        #1;
        chk("full_tag1", 64'(inst1_tag_out), 64'hFF);
        chk("full_tag2", 64'(inst2_tag_out), 64'hFF);
        tick();

        // Complete everything two per cycle (includes a hit on the free entry 1).
        for (int k = 0; k < 16; k++) begin
            idle();
            cdb1_tag_in   = 8'((2 + 2 * k) % N);
            cdb1_value_in = 64'(k) + 64'h500;
            cdb2_tag_in   = 8'((3 + 2 * k) % N);
            cdb2_value_in = 64'(k) + 64'h600;
            tick();
        end
        wait_empty();
        disp(1, 5'd6, 0, 5'd0);
        #1;
        chk("tail_kept", 64'(inst1_tag_out), 64'h01);
        tick();
        idle();
        cdb1_tag_in = 8'h01;
        tick();
        wait_empty();

        // Pointer wrap.
        churn_to(31);
        disp(1, 5'd8, 1, 5'd9);
        #1;
        chk("wrap_tag1", 64'(inst1_tag_out), 64'h1F);
        chk("wrap_tag2", 64'(inst2_tag_out), 64'h00);
        tick();
        idle();
        cdb1_tag_in = 8'h1F;
        cdb2_tag_in = 8'h00;
        tick();
        wait_empty();

        // inst2 alone.
        churn_to(5);
        disp(0, 5'd0, 1, 5'd10);
        #1;
        chk("i2only_tag1", 64'(inst1_tag_out), 64'hFF);
        chk("i2only_tag2", 64'(inst2_tag_out), 64'h05);
        tick();
        disp(1, 5'd11, 0, 5'd0);
        #1;
        chk("i2only_next", 64'(inst1_tag_out), 64'h06);
        tick();
        idle();
        cdb1_tag_in = 8'h05;
        cdb2_tag_in = 8'h06;
        tick();
        wait_empty();

        // Flush with ten live entries plus same-cycle dispatch and CDB.
        for (int i = 0; i < 5; i++) begin
            disp(1, 5'(i), 1, 5'(i + 7));
            tick();
        end
        disp(1, 5'd2, 1, 5'd3);
        flush_in      = 1'b1;
        cdb1_tag_in   = 8'h07;
        cdb1_value_in = 64'h77;
        #1;
        chk("fl_tag1", 64'(inst1_tag_out), 64'hFF);
        chk("fl_tag2", 64'(inst2_tag_out), 64'hFF);
        tick();
        idle();
        #1;
        chk("fl_empty", 64'(empty_out), 64'd1);
        disp(1, 5'h1f, 0, 5'd0);
        #1;
        chk("fl_next", 64'(inst1_tag_out), 64'h00);
        tick();

        // Both CDB ports name the same entry: CDB1 value must be kept.
        idle();
        cdb1_tag_in   = 8'h00;
        cdb1_value_in = 64'hAAAA;
        cdb2_tag_in   = 8'h40;
        cdb2_value_in = 64'hBBBB;
        tick();
        idle();
        #1;
        chk("prio_tag", 64'(inst1_retire_tag_out), 64'h00);
        chk("prio_val", inst1_retire_value_out, 64'hAAAA);
        chk("prio_dest", 64'(inst1_retire_dest_out), 64'h1f);
        tick();
        wait_empty();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
